axi_sram_slave: RTL and testbench
=================================

# axi_sram_slave

AXI3 slave memory that answers the CPU core's AXI master port: 32-bit data, 4-bit IDs, single outstanding transaction, FIXED/INCR bursts up to 16 beats. It connects directly to the core's `ar/r/aw/w/b` channels for simulation and on-chip boot RAM. Reads and writes share one state machine, and writes win on simultaneous requests. Accesses outside the configured window return SLVERR.

## Interface
- `ADDR_BITS`, 20: byte-address bits decoded by the memory (2^ADDR_BITS bytes, word-organised).
- `BASE`, 32'h1FC0_0000: window base; bits [31:ADDR_BITS] of an address must equal BASE[31:ADDR_BITS].
- `aclk` in 1: single clock; all logic on its rising edge.
- `aresetn` in 1: reset is synchronous and active-low.
- `arid` in 4, `araddr` in 32, `arlen` in 4, `arsize` in 3, `arburst` in 2: read address payload. `arlock`, `arcache` and `arprot` are accepted and ignored.
- `arvalid` in 1, `arready` out 1: read address handshake.
- `rid` out 4, `rdata` out 32, `rresp` out 2, `rlast` out 1, `rvalid` out 1, `rready` in 1: read data channel.
- `awid` in 4, `awaddr` in 32, `awlen` in 4, `awsize` in 3, `awburst` in 2: write address payload. `awlock`, `awcache` and `awprot` are ignored.
- `awvalid` in 1, `awready` out 1: write address handshake.
- `wid` in 4 (ignored), `wdata` in 32, `wstrb` in 4, `wlast` in 1 (ignored), `wvalid` in 1, `wready` out 1: write data channel.
- `bid` out 4, `bresp` out 2, `bvalid` out 1, `bready` in 1: write response channel.

## Operation
- **States:** IDLE, RD, WR, WRESP.
- **Reset:** the block goes to IDLE and every output is 0. Latched id, address and beat count are cleared. Memory contents are not reset.
- **IDLE:**
  - `awready = awvalid`.
  - `arready = arvalid & ~awvalid` (write priority).
  - An AW handshake latches id, addr, len, size, burst and goes to WR.
  - An AR handshake latches the same fields and goes to RD.
  - At most one handshake is accepted per cycle.
- **RD:**
  - Drive `rvalid = 1`, `rid` = latched id and `rdata = mem[addr[ADDR_BITS-1:2]]`.
  - `rlast = (beat == len)`.
  - `rresp = 2'b00`, or `2'b10` with `rdata = 0` if the address is outside the window.
  - On `rvalid & rready`:
    - Advance the address.
    - `beat++`.
    - After the last beat, go to IDLE.
- **WR:**
  - `wready = 1`.
  - On `wvalid & wready`, write byte lane i when `wstrb[i]` is set and the address is inside the window; out-of-window writes are dropped and a sticky error flag is set.
  - Advance the address and `beat++`.
  - The beat where `beat == len` ends the burst and the block goes to WRESP. The beat count is authoritative; `wlast` is not checked.
- **WRESP:**
  - `bvalid = 1`, `bid` = latched id.
  - `bresp = 2'b10` if the error flag is set, else `2'b00`.
  - On `bready`, go to IDLE and clear the flag.
- **Address advance:**
  - FIXED (2'b00): unchanged.
  - INCR (2'b01) and WRAP (2'b10, treated as INCR): `addr + (1 << min(size,2))`, 32-bit wrap-around.
  - Reserved burst 2'b11 is treated as FIXED.
- **Window check:** evaluated per beat on the current address, so an INCR burst crossing the window top errors only on the out-of-window beats.

## Timing
- **Read latency:** AR handshake in cycle T gives first `rvalid` in T+1. Each later beat follows one cycle after the previous handshake if `rready` is held high.
- **Write:** AW handshake in cycle T gives `wready` in T+1. The last W handshake in cycle U gives `bvalid` in U+1.
- **Handshake rules:**
  - `arready` and `awready` are combinational from state and the `*valid` inputs.
  - `rvalid` and `bvalid` stay asserted with stable payload until accepted.
- **Back-to-back:** the block returns to IDLE for at least one cycle between transactions.
- **Reset mid-burst:** the transaction is abandoned and all outputs are 0 in the cycle after reset is sampled low. Partially written beats remain in memory.

## Configuration
- **Macro:** `AXI_SLAVE_RAND_STALL_EN`.
- **Defined:**
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) is seeded 16'hACE1 at reset and steps every cycle.
  - `arready`, `awready`, `wready`, `rvalid` and `bvalid` are each ANDed with `lfsr[0]`.
  - A response already raised is never withdrawn until accepted: a sticky `valid_hold` bit overrides the mask.
- **Undefined:** no LFSR and no stalls; timing is exactly as in Timing.

## Test plan
- **Single-beat write then read:**
  - Stimulus: AW 0x1FC0_0010 id 1 len 0 size 2, W 0xDEADBEEF strb 4'hF, then AR same address id 0.
  - Required: `bresp` 0, `bid` 1, `rdata` 0xDEADBEEF, `rid` 0, `rlast` 1, `rvalid` one cycle after AR handshake.
- **Byte strobes:** pre-fill 0x11223344, write 0xAABBCCDD with strb 4'b0101. Required: read back 0x11BB33DD.
- **INCR burst with backpressure:**
  - Stimulus: write 4 beats 0..3 at 0x1FC0_0100, then AR len 3 with `rready` toggling 1,0,1,0.
  - Required: data 0,1,2,3 in order, payload stable during stalls, `rlast` only on beat 3.
- **Simultaneous requests:** `awvalid` and `arvalid` in the same IDLE cycle. Required: AW accepted first, `arready` 0 in that cycle, read served after WRESP completes.
- **Out-of-window access:**
  - Read at 0x0000_0000 (len 0) returns `rresp` 2'b10, `rdata` 0.
  - A write there returns `bresp` 2'b10 and memory is unchanged.
- **Reset mid-burst:** assert `aresetn` = 0 during beat 2 of an 8-beat read. Required: next cycle `rvalid` 0 and `arready` 0, then a new single-beat read completes normally.

Source files
------------

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 single-outstanding SRAM slave with a windowed address decode.
// Define AXI_SLAVE_RAND_STALL_EN to add LFSR-driven handshake stalls.
module axi_sram_slave #(
    parameter int          ADDR_BITS = 20,
    parameter logic [31:0] BASE      = 32'h1FC0_0000
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  id_q, id_d, len_q, len_d, beat_q, beat_d;
    logic [31:0] addr_q, addr_d, addr_nxt;
    logic [2:0]  size_q, size_d;
    logic [1:0]  burst_q, burst_d;
    logic        err_q, err_d;
    logic        in_win, go, resp_go;
    logic [31:0] mem [2**(ADDR_BITS-2)];
    logic        unused;

    assign unused = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid, wlast};

`ifdef AXI_SLAVE_RAND_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        valid_hold_q, valid_hold_d;
    assign go      = lfsr_q[0];
    assign resp_go = lfsr_q[0] | valid_hold_q;
    always_comb begin
        lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        valid_hold_d = (rvalid & ~rready) | (bvalid & ~bready);
    end
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            lfsr_q       <= 16'hACE1;
            valid_hold_q <= 1'b0;
        end else begin
            lfsr_q       <= lfsr_d;
            valid_hold_q <= valid_hold_d;
        end
    end
`else
    assign go      = 1'b1;
    assign resp_go = 1'b1;
`endif

    assign in_win   = addr_q[31:ADDR_BITS] == BASE[31:ADDR_BITS];
    assign addr_nxt = (burst_q == 2'b01 || burst_q == 2'b10)
                    ? addr_q + ((size_q >= 3'd2) ? 32'd4 : (32'd1 << size_q)) : addr_q;

    always_comb begin
        arready = go && state_q == IDLE && arvalid && !awvalid;
        awready = go && state_q == IDLE && awvalid;
        wready  = go && state_q == WR;
        rvalid  = resp_go && state_q == RD;
        rid     = (state_q == RD) ? id_q : 4'd0;
        rdata   = (state_q == RD && in_win) ? mem[addr_q[ADDR_BITS-1:2]] : 32'd0;
        rresp   = (state_q == RD && !in_win) ? 2'b10 : 2'b00;
        rlast   = state_q == RD && beat_q == len_q;
        bvalid  = resp_go && state_q == WRESP;
        bid     = (state_q == WRESP) ? id_q : 4'd0;
        bresp   = (state_q == WRESP && err_q) ? 2'b10 : 2'b00;
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        beat_d  = beat_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (awvalid && awready) begin
                    {id_d, addr_d, len_d, size_d, burst_d} = {awid, awaddr, awlen, awsize, awburst};
                    beat_d  = 4'd0;
                    state_d = WR;
                end else if (arvalid && arready) begin
                    {id_d, addr_d, len_d, size_d, burst_d} = {arid, araddr, arlen, arsize, arburst};
                    beat_d  = 4'd0;
                    state_d = RD;
                end
            end
            RD: begin
                if (rvalid && rready) begin
                    addr_d  = addr_nxt;
                    beat_d  = beat_q + 4'd1;
                    state_d = (beat_q == len_q) ? IDLE : RD;
                end
            end
            WR: begin
                if (wvalid && wready) begin
                    addr_d  = addr_nxt;
                    beat_d  = beat_q + 4'd1;
                    err_d   = err_q | !in_win;
                    state_d = (beat_q == len_q) ? WRESP : WR;
                end
            end
            default: begin
                if (bvalid && bready) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= IDLE;
            id_q    <= 4'd0;
            addr_q  <= 32'd0;
            len_q   <= 4'd0;
            size_q  <= 3'd0;
            burst_q <= 2'b00;
            beat_q  <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    // Contents survive reset; out-of-window beats never reach the array.
    always_ff @(posedge aclk) begin
        if (aresetn && state_q == WR && wvalid && wready && in_win)
            for (int i = 0; i < 4; i++)
                if (wstrb[i]) mem[addr_q[ADDR_BITS-1:2]][8*i +: 8] <= wdata[8*i +: 8];
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed self-checking bench for axi_sram_slave.
module tb_axi_sram_slave;
    logic        aclk = 1'b0, aresetn = 1'b0;
    logic [3:0]  arid = '0, awid = '0, wid = '0, arlen = '0, awlen = '0, arcache = '0, awcache = '0;
    logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
    logic [2:0]  arsize = '0, awsize = '0, arprot = '0, awprot = '0;
    logic [1:0]  arburst = '0, awburst = '0, arlock = '0, awlock = '0;
    logic [3:0]  wstrb = '0;
    logic        arvalid = 0, awvalid = 0, wvalid = 0, wlast = 0, rready = 0, bready = 0;
    logic        arready, awready, wready, rvalid, rlast, bvalid;
    logic [3:0]  rid, bid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;
    int checks = 0, errors = 0;

    axi_sram_slave dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send_aw(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len);
        int n = 0;
        @(negedge aclk);
        awid = id; awaddr = a; awlen = len; awsize = 3'd2; awburst = 2'b01; awvalid = 1;
        #1;
        while (awready !== 1'b1 && n < 20) begin @(negedge aclk); #1; n++; end
        checks++;
        if (awready !== 1'b1) begin errors++; $display("FAIL aw_wait: awready=%b required 1", awready); end
        @(posedge aclk); #1 awvalid = 0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        @(negedge aclk);
        wdata = d; wstrb = s; wvalid = 1;
        #1;
        while (wready !== 1'b1 && n < 20) begin @(negedge aclk); #1; n++; end
        checks++;
        if (wready !== 1'b1) begin errors++; $display("FAIL w_wait: wready=%b required 1", wready); end
        @(posedge aclk); #1 wvalid = 0;
    endtask

    task automatic recv_b(output logic [1:0] rs, output logic [3:0] i);
        int n = 0;
        @(negedge aclk);
        bready = 1;
        #1;
        while (bvalid !== 1'b1 && n < 20) begin @(negedge aclk); #1; n++; end
        checks++;
        if (bvalid !== 1'b1) begin errors++; $display("FAIL b_wait: bvalid=%b required 1", bvalid); end
        rs = bresp; i = bid;
        @(posedge aclk); #1 bready = 0;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len);
        int n = 0;
        @(negedge aclk);
        arid = id; araddr = a; arlen = len; arsize = 3'd2; arburst = 2'b01; arvalid = 1;
        #1;
        while (arready !== 1'b1 && n < 20) begin @(negedge aclk); #1; n++; end
        checks++;
        if (arready !== 1'b1) begin errors++; $display("FAIL ar_wait: arready=%b required 1", arready); end
        @(posedge aclk); #1 arvalid = 0;
    endtask

    task automatic recv_r(output logic [31:0] d, output logic [1:0] rs, output logic [3:0] i, output logic l);
        int n = 0;
        @(negedge aclk);
        rready = 1;
        #1;
        while (rvalid !== 1'b1 && n < 20) begin @(negedge aclk); #1; n++; end
        checks++;
        if (rvalid !== 1'b1) begin errors++; $display("FAIL r_wait: rvalid=%b required 1", rvalid); end
        d = rdata; rs = rresp; i = rid; l = rlast;
        @(posedge aclk); #1 rready = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checks++;
        if ({arready, awready, wready, rvalid, bvalid, rlast} !== 6'b0 || rdata !== 32'd0 || {rid, bid, rresp, bresp} !== 12'd0) begin
            errors++; $display("FAIL reset_outputs: ready/valid=%b required 000000", {arready, awready, wready, rvalid, bvalid, rlast});
        end
        aresetn = 1;
        @(negedge aclk); #1;
        checks++;
        if ({arready, awready, wready, rvalid, bvalid} !== 5'b0) begin
            errors++; $display("FAIL post_reset_idle: ready/valid=%b required 00000", {arready, awready, wready, rvalid, bvalid});
        end
    endtask

    task automatic test_single();
        logic [31:0] d; logic [1:0] rs; logic [3:0] i; logic l;
        send_aw(4'd1, 32'h1FC0_0010, 4'd0);
        checks++;
        if (wready !== 1'b1) begin errors++; $display("FAIL single_wready_latency: wready=%b required 1", wready); end
        send_w(32'hDEADBEEF, 4'hF);
        checks++;
        if (bvalid !== 1'b1) begin errors++; $display("FAIL single_bvalid_latency: bvalid=%b required 1", bvalid); end
        recv_b(rs, i);
        checks++;
        if (rs !== 2'b00 || i !== 4'd1) begin errors++; $display("FAIL single_b: bresp=%b bid=%0d required 00 1", rs, i); end
        send_ar(4'd0, 32'h1FC0_0010, 4'd0);
        checks++;
        if (rvalid !== 1'b1) begin errors++; $display("FAIL single_rvalid_latency: rvalid=%b required 1", rvalid); end
        recv_r(d, rs, i, l);
        checks++;
        if (d !== 32'hDEADBEEF || rs !== 2'b00 || i !== 4'd0 || l !== 1'b1) begin
            errors++; $display("FAIL single_r: rdata=%h rresp=%b rid=%0d rlast=%b required deadbeef 00 0 1", d, rs, i, l);
        end
    endtask

    task automatic test_strobes();
        logic [31:0] d; logic [1:0] rs; logic [3:0] i; logic l;
        send_aw(4'd2, 32'h1FC0_0020, 4'd0);
        send_w(32'h11223344, 4'hF);
        recv_b(rs, i);
        send_aw(4'd2, 32'h1FC0_0020, 4'd0);
        send_w(32'hAABBCCDD, 4'b0101);
        recv_b(rs, i);
        send_ar(4'd2, 32'h1FC0_0020, 4'd0);
        recv_r(d, rs, i, l);
        checks++;
        if (d !== 32'h11BB33DD) begin errors++; $display("FAIL strobes: rdata=%h required 11bb33dd", d); end
    endtask

    task automatic test_incr_burst();
        logic [1:0] rs; logic [3:0] i;
        send_aw(4'd3, 32'h1FC0_0100, 4'd3);
        for (int k = 0; k < 4; k++) send_w(k, 4'hF);
        recv_b(rs, i);
        checks++;
        if (rs !== 2'b00 || i !== 4'd3) begin errors++; $display("FAIL burst_b: bresp=%b bid=%0d required 00 3", rs, i); end
        send_ar(4'd7, 32'h1FC0_0100, 4'd3);
        for (int k = 0; k < 4; k++) begin
            @(negedge aclk); rready = 1; #1;
            checks++;
            if (rvalid !== 1'b1 || rdata !== k || rlast !== (k == 3) || rid !== 4'd7) begin
                errors++; $display("FAIL burst_beat%0d: rvalid=%b rdata=%h rlast=%b required 1 %h %b", k, rvalid, rdata, rlast, k, k == 3);
            end
            @(posedge aclk); #1 rready = 0;
            if (k < 3) begin
                @(negedge aclk); #1;
                checks++;
                if (rvalid !== 1'b1 || rdata !== k + 1 || rlast !== (k == 2)) begin
                    errors++; $display("FAIL burst_stall%0d: rvalid=%b rdata=%h rlast=%b required 1 %h %b", k, rvalid, rdata, rlast, k + 1, k == 2);
                end
            end
        end
        @(negedge aclk); #1;
        checks++;
        if (rvalid !== 1'b0) begin errors++; $display("FAIL burst_end: rvalid=%b required 0", rvalid); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] d; logic [1:0] rs; logic [3:0] i; logic l;
        @(negedge aclk);
        awid = 4'd3; awaddr = 32'h1FC0_0200; awlen = 0; awsize = 3'd2; awburst = 2'b01; awvalid = 1;
        arid = 4'd4; araddr = 32'h1FC0_0200; arlen = 0; arsize = 3'd2; arburst = 2'b01; arvalid = 1;
        #1;
        checks++;
        if (awready !== 1'b1 || arready !== 1'b0) begin errors++; $display("FAIL simul_priority: awready=%b arready=%b required 1 0", awready, arready); end
        @(posedge aclk); #1 awvalid = 0;
        checks++;
        if (arready !== 1'b0 || wready !== 1'b1) begin errors++; $display("FAIL simul_wr: arready=%b wready=%b required 0 1", arready, wready); end
        send_w(32'h55AA55AA, 4'hF);
        checks++;
        if (arready !== 1'b0 || bvalid !== 1'b1) begin errors++; $display("FAIL simul_wresp: arready=%b bvalid=%b required 0 1", arready, bvalid); end
        recv_b(rs, i);
        checks++;
        if (rs !== 2'b00 || i !== 4'd3) begin errors++; $display("FAIL simul_b: bresp=%b bid=%0d required 00 3", rs, i); end
        checks++;
        if (arready !== 1'b1) begin errors++; $display("FAIL simul_ar_after: arready=%b required 1", arready); end
        @(posedge aclk); #1 arvalid = 0;
        recv_r(d, rs, i, l);
        checks++;
        if (d !== 32'h55AA55AA || i !== 4'd4 || l !== 1'b1) begin
            errors++; $display("FAIL simul_r: rdata=%h rid=%0d rlast=%b required 55aa55aa 4 1", d, i, l);
        end
    endtask

    task automatic test_out_of_window();
        logic [31:0] d; logic [1:0] rs; logic [3:0] i; logic l;
        send_aw(4'd8, 32'h1FC0_0000, 4'd0);
        send_w(32'hCAFEF00D, 4'hF);
        recv_b(rs, i);
        send_ar(4'd9, 32'h0000_0000, 4'd0);
        recv_r(d, rs, i, l);
        checks++;
        if (rs !== 2'b10 || d !== 32'd0 || l !== 1'b1 || i !== 4'd9) begin
            errors++; $display("FAIL oow_read: rresp=%b rdata=%h rlast=%b rid=%0d required 10 0 1 9", rs, d, l, i);
        end
        send_aw(4'd10, 32'h0000_0000, 4'd0);
        send_w(32'h12345678, 4'hF);
        recv_b(rs, i);
        checks++;
        if (rs !== 2'b10 || i !== 4'd10) begin errors++; $display("FAIL oow_write: bresp=%b bid=%0d required 10 10", rs, i); end
        send_ar(4'd11, 32'h1FC0_0000, 4'd0);
        recv_r(d, rs, i, l);
        checks++;
        if (d !== 32'hCAFEF00D || rs !== 2'b00) begin errors++; $display("FAIL oow_mem_unchanged: rdata=%h rresp=%b required cafef00d 00", d, rs); end
    endtask

    task automatic test_reset_mid_burst();
        logic [31:0] d; logic [1:0] rs; logic [3:0] i; logic l;
        send_ar(4'd5, 32'h1FC0_0100, 4'd7);
        recv_r(d, rs, i, l);
        recv_r(d, rs, i, l);
        checks++;
        if (d !== 32'd1 || l !== 1'b0) begin errors++; $display("FAIL mid_beat1: rdata=%h rlast=%b required 1 0", d, l); end
        @(negedge aclk); aresetn = 0;
        @(posedge aclk); #1;
        checks++;
        if (rvalid !== 1'b0 || arready !== 1'b0) begin errors++; $display("FAIL mid_reset: rvalid=%b arready=%b required 0 0", rvalid, arready); end
        @(negedge aclk); aresetn = 1;
        send_ar(4'd6, 32'h1FC0_0104, 4'd0);
        recv_r(d, rs, i, l);
        checks++;
        if (d !== 32'd1 || rs !== 2'b00 || l !== 1'b1 || i !== 4'd6) begin
            errors++; $display("FAIL mid_after: rdata=%h rresp=%b rlast=%b rid=%0d required 1 00 1 6", d, rs, l, i);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_strobes();
        test_incr_burst();
        test_simultaneous();
        test_out_of_window();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
